// File: rtl/pcs_scrambler_lane.sv
// ---------------------------------------------------------------------------
// pcs_scrambler_lane
//
// Self-synchronous 64b/66b scrambler / descrambler for the 10GBASE-R PCS
// datapath, polynomial 1 + x^39 + x^58, processing DATA_WIDTH bits per word.
// Sits between the encoder and the TX gearbox (DESCRAMBLE=0) or between the
// RX gearbox and the decoder (DESCRAMBLE=1).
//
// Parameters:
//   DATA_WIDTH  payload bits per word (16, 32 or 64)
//   DESCRAMBLE  0 = scrambler (history from output), 1 = descrambler
//               (history from input)
//
// Ports:
//   clk        datapath clock
//   reset_n    asynchronous active-low reset
//   init_done  link init complete; low holds the block in INIT
//   i_valid    idata carries a word this cycle
//   idata      input word, bit 0 is the first transmitted bit
//   bypass     (only with SCR_BYPASS_EN) pass accepted words through as-is
//   seed_load  load seed into the history this cycle
//   seed       seed value, bit 57 is the most recent bit
//   o_valid    odata valid (one cycle after the accepted word)
//   odata      scrambled / descrambled word
//   o_primed   at least 58 history bits come from real traffic or a seed
//
// Optional feature: define SCR_BYPASS_EN to add the bypass input.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pcs_scrambler_lane #(
  parameter int DATA_WIDTH = 32,
  parameter bit DESCRAMBLE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_done,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] idata,
`ifdef SCR_BYPASS_EN
  input  logic                  bypass,
`endif
  input  logic                  seed_load,
  input  logic [57:0]           seed,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  o_primed
);

  localparam int STATE_BITS = 58;
  localparam int EXT_BITS   = STATE_BITS + DATA_WIDTH;

  if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("pcs_scrambler_lane: DATA_WIDTH must be 16, 32 or 64");
  end

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                  state, state_next;
  logic [STATE_BITS-1:0]   hist, hist_next;
  logic [6:0]              cnt, cnt_next;
  logic [DATA_WIDTH-1:0]   odata_next;
  logic                    o_valid_next;
  logic                    o_primed_next;

  logic [STATE_BITS-1:0]   cur_hist;
  logic [EXT_BITS-1:0]     ext;
  logic [DATA_WIDTH-1:0]   word_out;
  logic [STATE_BITS-1:0]   hist_shifted;
  logic [7:0]              cnt_sum;
  logic [6:0]              cnt_adv;
  logic                    bypass_word;

  // The state register only remembers whether the previous cycle was held in
  // INIT. Leaving INIT is immediate: the first cycle with init_done high
  // already processes its word, so there is no wait state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Parallel unrolled scrambler. The ext vector is the serial b-stream laid
  // out oldest-first: the 58 history bits at the bottom, followed by this
  // word's b bits as they are produced. For word bit i (stream bit n), ext[i]
  // is b[n-58] and ext[i+19] is b[n-39], whether those come from history or
  // from earlier bits of the same word. The loop runs in bit order so every
  // tap it reads has already been written. The new history is simply the
  // newest 58 bits of ext, which for a 64-bit word drops the 6 oldest bits.
  // A seed replaces the history feeding the word; coming out of INIT the
  // history is all-ones regardless of what the register holds.
  always_comb begin
    cur_hist = hist;
    if (seed_load) begin
      cur_hist = seed;
    end else if (state == ST_INIT) begin
      cur_hist = '1;
    end

    ext      = '0;
    word_out = '0;
    ext[STATE_BITS-1:0] = cur_hist;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      word_out[i] = idata[i] ^ ext[i+19] ^ ext[i];
      ext[STATE_BITS+i] = DESCRAMBLE ? idata[i] : word_out[i];
    end
    hist_shifted = ext[EXT_BITS-1 -: STATE_BITS];

    cnt_sum = {1'b0, cnt} + 8'(DATA_WIDTH);
    cnt_adv = cnt_sum[7] ? 7'h7F : cnt_sum[6:0];
  end

  // Next-state and register-input logic. Dropping init_done wins over
  // everything and re-arms the block exactly as reset does, except that odata
  // keeps its last value. In RUN a seed overrides the history (and marks it
  // trustworthy at once by saturating the counter); an accepted word then
  // shifts the history from whatever fed it. A bypassed word leaves history
  // and counter untouched.
  always_comb begin
    state_next    = init_done ? ST_RUN : ST_INIT;
    hist_next     = hist;
    cnt_next      = cnt;
    odata_next    = odata;
    o_valid_next  = 1'b0;
    o_primed_next = o_primed;

`ifdef SCR_BYPASS_EN
    bypass_word = bypass;
`else
    bypass_word = 1'b0;
`endif

    if (!init_done) begin
      hist_next     = '1;
      cnt_next      = '0;
      o_primed_next = 1'b0;
    end else begin
      if (seed_load) begin
        hist_next = seed;
        cnt_next  = 7'h7F;
      end else if (state == ST_INIT) begin
        hist_next = '1;
      end

      if (i_valid) begin
        o_valid_next = 1'b1;
        if (bypass_word) begin
          odata_next = idata;
        end else begin
          odata_next = word_out;
          hist_next  = hist_shifted;
          cnt_next   = seed_load ? 7'h7F : cnt_adv;
        end
      end

      o_primed_next = (cnt_next >= 7'd58);
    end
  end

  // Datapath registers: one cycle of latency from accepted word to odata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist     <= '1;
      cnt      <= '0;
      odata    <= '0;
      o_valid  <= 1'b0;
      o_primed <= 1'b0;
    end else begin
      hist     <= hist_next;
      cnt      <= cnt_next;
      odata    <= odata_next;
      o_valid  <= o_valid_next;
      o_primed <= o_primed_next;
    end
  end

endmodule
